// File: rtl/scan_ctrl.sv
// scan_ctrl: 8-digit multiplexed 7-segment scanner with leading-zero blanking.
// Latency: each digit gets GAP blank cycles then DIV lit cycles; a frame is 8*(GAP+DIV) cycles.
// No backpressure: en gates scanning (drop aborts at once), outputs are registered.
module scan_ctrl #(
  parameter int unsigned DIV = 1000,
  parameter int unsigned GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lz_en,
  input  logic [3:0] digit,
  output logic [2:0] flag,
  output logic [7:0] dig_n,
  output logic [6:0] seg_n,
  output logic       frame
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  flag_q;
  logic        lz_q;
  logic [3:0]  digit_q;
  logic [7:0]  dig_n_q;
  logic [6:0]  seg_n_q;
  logic        frame_q;

  logic        blank_d;
  logic [7:0]  sel_n_d;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex 0-F.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Blank only while every digit latched so far this frame was zero; digit 0 always shows.
  assign blank_d = lz_en && lz_q && (digit == 4'd0) && (flag_q != 3'd0);
  assign sel_n_d = ~(8'd1 << flag_q);

  // Scan FSM: counter, digit select, leading-zero tracking and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      flag_q  <= 3'd7;
      lz_q    <= 1'b1;
      digit_q <= 4'd0;
      dig_n_q <= 8'hFF;
      seg_n_q <= 7'h7F;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_GAP;
            cnt_q   <= 16'd0;
            flag_q  <= 3'd7;
            lz_q    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (!en) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            flag_q  <= 3'd7;
            lz_q    <= 1'b1;
            dig_n_q <= 8'hFF;
            seg_n_q <= 7'h7F;
          end else if (cnt_q == GAP_LAST) begin
            // Mux has settled on flag_q for the whole gap; sample the digit now.
            state_q <= ST_SHOW;
            cnt_q   <= 16'd0;
            digit_q <= digit;
            dig_n_q <= blank_d ? 8'hFF : sel_n_d;
            seg_n_q <= blank_d ? 7'h7F : hex7(digit);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_SHOW: begin
          if (!en) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            flag_q  <= 3'd7;
            lz_q    <= 1'b1;
            dig_n_q <= 8'hFF;
            seg_n_q <= 7'h7F;
          end else begin
            if (digit_q != 4'd0) lz_q <= 1'b0;
            if (cnt_q == DIV_LAST) begin
              state_q <= ST_GAP;
              cnt_q   <= 16'd0;
              flag_q  <= flag_q - 3'd1;
              dig_n_q <= 8'hFF;
              seg_n_q <= 7'h7F;
              if (flag_q == 3'd0) begin
                // Digit 0 done: frame boundary, re-arm leading-zero blanking.
                frame_q <= 1'b1;
                lz_q    <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flag  = flag_q;
  assign dig_n = dig_n_q;
  assign seg_n = seg_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: scoreboard bench for scan_ctrl with DIV=4, GAP=2.
// Stimulus pushes the expected output word for every clock edge; a negedge monitor pops and compares.
// The digit input comes from a model of the 8:1 mux driven by the DUT's flag output.
module tb_scan_ctrl;

  localparam int DIV   = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = GAP + DIV;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       lz_en;
  logic [3:0] digit;
  logic [2:0] flag;
  logic [7:0] dig_n;
  logic [6:0] seg_n;
  logic       frame;

  logic [7:0][3:0] dv;
  assign digit = dv[flag];

  scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .lz_en (lz_en),
    .digit (digit),
    .flag  (flag),
    .dig_n (dig_n),
    .seg_n (seg_n),
    .frame (frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] flag;
    logic [7:0] dig_n;
    logic [6:0] seg_n;
    logic       frame;
  } obs_t;

  localparam obs_t IDLE_OBS = '{flag: 3'd7, dig_n: 8'hFF, seg_n: 7'h7F, frame: 1'b0};

  obs_t  exp_q[$];
  string tag_q[$];
  string scen;
  int    checks   = 0;
  int    failures = 0;

  // Reference model state: position within the frame, and what is being displayed.
  bit         m_idle;
  int         m_t;
  bit         m_fresh;
  bit         m_lead;
  logic [3:0] m_val;
  bit         m_blank;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g [16];
    g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return g[v];
  endfunction

  // Predict the outputs after the next rising edge, then let that edge happen.
  task automatic cyc();
    obs_t       e;
    int         slot;
    int         ph;
    logic [2:0] fl;
    if (rst || !en) begin
      m_idle = 1'b1;
      e      = IDLE_OBS;
    end else begin
      if (m_idle) begin
        m_idle  = 1'b0;
        m_t     = 0;
        m_fresh = 1'b1;
      end else begin
        m_t++;
        if (m_t == FRAME) begin
          m_t     = 0;
          m_fresh = 1'b0;
        end
      end
      slot = m_t / SLOT;
      ph   = m_t % SLOT;
      fl   = 3'(7 - slot);
      if (m_t == 0) m_lead = 1'b1;
      if (ph == GAP) begin
        m_val   = dv[fl];
        m_blank = lz_en && (fl != 3'd0) && m_lead && (m_val == 4'd0);
        if (m_val != 4'd0) m_lead = 1'b0;
      end
      e.flag  = fl;
      e.frame = (m_t == 0) && !m_fresh;
      if (ph < GAP || m_blank) begin
        e.dig_n = 8'hFF;
        e.seg_n = 7'h7F;
      end else begin
        e.dig_n = ~(8'h01 << fl);
        e.seg_n = glyph(m_val);
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(scen);
    #1;
  endtask

  task automatic restart();
    en = 1'b0;
    cyc();
    en = 1'b1;
  endtask

  // Run until the cycle just checked sits at frame position t (bounded by one frame).
  task automatic run_to(input int t);
    for (int i = 0; i < FRAME + 2; i++) begin
      if (!m_idle && m_t == t) break;
      cyc();
    end
  endtask

  // Monitor: compare every presented output word against the scoreboard.
  obs_t  mon_e;
  obs_t  mon_a;
  string mon_tag;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_a.flag  = flag;
      mon_a.dig_n = dig_n;
      mon_a.seg_n = seg_n;
      mon_a.frame = frame;
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL %s t=%0t got flag=%0d dig_n=%h seg_n=%h frame=%b expected flag=%0d dig_n=%h seg_n=%h frame=%b",
                 mon_tag, $time, mon_a.flag, mon_a.dig_n, mon_a.seg_n, mon_a.frame,
                 mon_e.flag, mon_e.dig_n, mon_e.seg_n, mon_e.frame);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; lz_en = 1'b0; dv = '0;
    m_idle = 1'b1; m_t = 0; m_fresh = 1'b1; m_lead = 1'b1; m_val = 4'd0; m_blank = 1'b0;

    scen = "reset";
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    scen = "basic";
    dv = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    en = 1'b1;
    repeat (2 * FRAME + 2) cyc();

    scen = "lead_zero";
    dv = {4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    lz_en = 1'b1;
    restart();
    repeat (2 * FRAME) cyc();

    scen = "all_zero";
    dv = '0;
    restart();
    repeat (2 * FRAME + 1) cyc();

    scen = "abort";
    dv = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    lz_en = 1'b0;
    restart();
    run_to(4 * SLOT + GAP + 1);
    en = 1'b0;
    cyc();
    en = 1'b1;
    repeat (FRAME + 3) cyc();

    scen = "reset_mid_show";
    run_to(7 * SLOT + GAP + 1);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    repeat (FRAME + 4) cyc();

    scen = "mid_digit_change";
    dv = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    restart();
    run_to(2 * SLOT + GAP + 1);
    dv[5] = 4'd9;
    repeat (FRAME + FRAME / 2) cyc();

    scen = "random";
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++)
        dv[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      lz_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin
          en = 1'b0;
          repeat ($urandom_range(1, 3)) cyc();
        end
        1: begin
          rst = 1'b1;
          en  = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 2)) cyc();
        end
        default: ;
      endcase
      rst = 1'b0;
      en  = 1'b1;
      repeat ($urandom_range(1, 60)) cyc();
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected words left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles each digit is lit (SHOW phase), legal range 1..65535.
REQ-002 SHALL have parameter GAP, default 8: clock cycles of blanking before each digit (GAP phase), legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: scan enable; 1 = run, 0 = idle.
REQ-006 SHALL have port lz_en, input, 1 bit: 1 = blank leading zeros.
REQ-007 SHALL have port digit, input, 4 bits: the nibble currently selected by the 8:1 digit mux for flag.
REQ-008 SHALL have port flag, output, 3 bits: registered select for the 8:1 digit mux.
REQ-009 SHALL have port dig_n, output, 8 bits: active-low one-hot digit enable, registered; bit k drives digit k.
REQ-010 SHALL have port seg_n, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 SHALL have port frame, output, 1 bit: one-cycle pulse when digit 0's SHOW phase ends.

Function
REQ-012 SHALL implement states IDLE, GAP and SHOW with a 16-bit phase counter.
- In IDLE: dig_n = 8'hFF, seg_n = 7'h7F, flag = 7.
REQ-013 IDLE with en=1 SHALL move to GAP on the next edge with counter = 0.
REQ-014 GAP SHALL last exactly GAP cycles.
- Output: dig_n = 8'hFF, seg_n = 7'h7F; flag stable.
REQ-015 On the last GAP cycle the block SHALL latch digit into digit_q and compute the blank decision, then enter SHOW.
REQ-016 SHOW SHALL last exactly DIV cycles.
- Output: dig_n has only bit[flag] low, unless the digit is blanked (then 8'hFF).
- seg_n = hex decode of digit_q when not blanked, 7'h7F when blanked.
REQ-017 Hex decode SHALL be standard 0-F, active-low, {g..a} order.
- 0 -> 7'h40, 1 -> 7'h79, 2 -> 7'h24, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
REQ-018 Scan order SHALL be flag 7,6,...,0, then wrap to 7.
- flag updates on the edge leaving SHOW, so every GAP starts with the new flag (mux settling time).
REQ-019 Leading-zero flag lz SHALL be set to 1 at each frame start (flag = 7 entering GAP).
- lz clears to 0 when a latched digit_q != 0.
REQ-020 A digit SHALL be blanked only when lz_en = 1, lz = 1, digit_q = 0 and flag != 0.
- Digit 0 is never blanked (display "0" when all digits are zero).
REQ-021 On the edge leaving SHOW with flag = 0: frame = 1 for exactly that next cycle, flag <= 7, lz <= 1; at all other times frame = 0.
REQ-022 Frame period SHALL be 8*(GAP+DIV) cycles, exactly, while en stays 1.
REQ-023 en = 0 in GAP or SHOW SHALL abort immediately.
- Next cycle: IDLE, dig_n = 8'hFF, seg_n = 7'h7F, flag = 7, no frame pulse.
- Re-enable restarts from digit 7.
REQ-024 Changing lz_en or digit mid-SHOW SHALL NOT alter the current SHOW outputs; changes take effect from the next latch point.
REQ-025 rst SHALL override en when both are high in the same cycle.

Reset
REQ-026 rst = 1 at a clock edge SHALL force, on that edge:
- state = IDLE, counter = 0, flag = 3'd7, lz = 1, digit_q = 0;
- dig_n = 8'hFF, seg_n = 7'h7F, frame = 0.
REQ-027 Reset asserted mid-SHOW SHALL take effect on that same edge with no partial digit or frame pulse.
REQ-028 Outputs SHALL be defined (no X) from the first edge with rst = 1.

Verification (DIV = 4, GAP = 2; digit driven by a model of the 8:1 mux over digits d7..d0)
REQ-029 Basic scan: d7..d0 = 1,2,3,4,5,6,7,8; lz_en = 0; en = 1 after reset.
- flag sequence 7..0: each digit GAP 2 cycles (dig_n = FF), then SHOW 4 cycles.
- First SHOW: dig_n = 8'h7F, seg_n = 7'h79.
- frame pulses every 48 cycles.
REQ-030 Leading zero: d7..d0 = 0,0,0,5,0,0,0,0; lz_en = 1.
- Digits 7..5 dark (dig_n = FF throughout).
- Digit 4 shows 5; digits 3..1 show 7'h40; digit 0 shows 7'h40.
REQ-031 All zero: all digits 0, lz_en = 1.
- Only digit 0 lit (dig_n = 8'hFE, seg_n = 7'h40); other SHOW phases dark.
- Same for the next frame (lz re-armed).
REQ-032 Abort: en drops on the 2nd SHOW cycle of flag = 3.
- Next cycle: dig_n = FF, flag = 7, no frame pulse.
- en = 1 again: scan restarts at 7 after 2 GAP cycles.
REQ-033 Reset mid-SHOW: assert rst on a SHOW cycle of flag = 0 with en = 1.
- No frame pulse; flag = 7, outputs idle next cycle.
- rst and en both high: block stays IDLE.
REQ-034 Mid-digit change: digit changes from 3 to 9 during SHOW of flag = 5.
- seg_n holds 7'h30 until that SHOW ends.
